// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM encoding and the FIPS 180-4 logical functions.
package sha256_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRound,
    StUpdate,
    StDone
  } state_e;

  // LOAD + 64 rounds + UPDATE
  localparam int unsigned BLOCK_CYCLES = 66;
  localparam logic [5:0]  LAST_ROUND   = 6'(BLOCK_CYCLES - 3);

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: 16-word sliding window, W_t presented at the window head.
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [511:0] i_block,
  output logic [31:0]  o_w
);

  logic [15:0][31:0] r_win;
  logic [31:0]       w_next;

  // W_{t+16} from W_t, W_{t+1}, W_{t+9}, W_{t+14}
  assign w_next = small_sigma1(r_win[14]) + r_win[9] + small_sigma0(r_win[1]) + r_win[0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_win <= '0;
    end else if (i_load) begin
      for (int i = 0; i < 16; i++) begin
        r_win[i] <= i_block[511 - 32*i -: 32];
      end
    end else if (i_shift) begin
      for (int i = 0; i < 15; i++) begin
        r_win[i] <= r_win[i+1];
      end
      r_win[15] <= w_next;
    end
  end

  assign o_w = r_win[0];

endmodule

// File: rtl/sha256_core.sv
// Multi-block SHA-256 over a fixed 96- or 128-byte message with internal padding.
module sha256_core
  import sha256_pkg::*;
#(
  parameter int unsigned SHORT_MSG_BITS = 768,
  parameter int unsigned LONG_MSG_BITS  = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          hash_start,
  input  logic [1023:0] hash_data_in,
  input  logic          message_length,
  output logic          hash_done,
  output logic [255:0]  hash_data_out
);

  state_e           r_state, w_state_next;
  logic [1023:0]    r_msg;
  logic             r_long;
  logic [1:0]       r_blk;
  logic [5:0]       r_round;
  logic [7:0][31:0] r_h;
  logic [7:0][31:0] r_v;
  logic             r_done;
  logic [255:0]     r_digest;

  logic             w_last_blk;
  logic [511:0]     w_block;
  logic [31:0]      w_w;
  logic [31:0]      w_t1;
  logic [31:0]      w_t2;
  logic [7:0][31:0] w_base;
  logic [7:0][31:0] w_sum;

  assign w_last_blk = (r_blk == (r_long ? 2'd2 : 2'd1));

  // Padded block selection; the short message ends mid-way through block 1.
  always_comb begin
    w_block = '0;
    case (r_blk)
      2'd0: w_block = r_msg[1023:512];
      2'd1: w_block = r_long ? r_msg[511:0]
                             : {r_msg[511:256], 32'h8000_0000, 160'h0, 64'(SHORT_MSG_BITS)};
      2'd2: w_block = {32'h8000_0000, 416'h0, 64'(LONG_MSG_BITS)};
      default: w_block = '0;
    endcase
  end

  always_comb begin
    w_t1 = r_v[7] + big_sigma1(r_v[4]) + ch(r_v[4], r_v[5], r_v[6]) + K[r_round] + w_w;
    w_t2 = big_sigma0(r_v[0]) + maj(r_v[0], r_v[1], r_v[2]);
    for (int i = 0; i < 8; i++) begin
      w_base[i] = (r_blk == 2'd0) ? IV[i] : r_h[i];
      w_sum[i]  = r_h[i] + r_v[i];
    end
  end

  sha256_msg_schedule u_msg_schedule (
    .clk     (clk),
    .reset   (reset),
    .i_load  (r_state == StLoad),
    .i_shift (r_state == StRound),
    .i_block (w_block),
    .o_w     (w_w)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:   if (hash_start) w_state_next = StLoad;
      StLoad:   w_state_next = StRound;
      StRound:  if (r_round == LAST_ROUND) w_state_next = StUpdate;
      StUpdate: w_state_next = w_last_blk ? StDone : StLoad;
      StDone:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_msg    <= '0;
      r_long   <= 1'b0;
      r_blk    <= '0;
      r_round  <= '0;
      r_h      <= '0;
      r_v      <= '0;
      r_done   <= 1'b0;
      r_digest <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (hash_start) begin
            r_msg   <= hash_data_in;
            r_long  <= message_length;
            r_blk   <= '0;
            r_round <= '0;
          end
        end
        StLoad: begin
          r_h <= w_base;
          r_v <= w_base;
        end
        StRound: begin
          // Counter wraps 63 -> 0 as the FSM leaves ROUND.
          r_round <= r_round + 6'd1;
          r_v[7]  <= r_v[6];
          r_v[6]  <= r_v[5];
          r_v[5]  <= r_v[4];
          r_v[4]  <= r_v[3] + w_t1;
          r_v[3]  <= r_v[2];
          r_v[2]  <= r_v[1];
          r_v[1]  <= r_v[0];
          r_v[0]  <= w_t1 + w_t2;
        end
        StUpdate: begin
          r_h <= w_sum;
          if (w_last_blk) begin
            r_done   <= 1'b1;
            r_digest <= {w_sum[0], w_sum[1], w_sum[2], w_sum[3],
                         w_sum[4], w_sum[5], w_sum[6], w_sum[7]};
            r_blk    <= '0;
          end else begin
            r_blk <= r_blk + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign hash_done     = r_done;
  assign hash_data_out = r_digest;

endmodule

// File: tb/tb_sha256_core.sv
// Directed bench for sha256_core, checked against an independent byte-level SHA-256 model.
module tb_sha256_core;

  logic          clk;
  logic          reset;
  logic          hash_start;
  logic [1023:0] hash_data_in;
  logic          message_length;
  logic          hash_done;
  logic [255:0]  hash_data_out;

  int tests_run;
  int tests_failed;

  sha256_core #(
    .SHORT_MSG_BITS (768),
    .LONG_MSG_BITS  (1024)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .hash_start     (hash_start),
    .hash_data_in   (hash_data_in),
    .message_length (message_length),
    .hash_done      (hash_done),
    .hash_data_out  (hash_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] TB_IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] TB_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] tb_rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference SHA-256 of the first n bytes of data (byte 0 in [1023:1016]), n <= 128.
  function automatic logic [255:0] sha_ref(input logic [1023:0] data, input int n);
    logic [7:0]  pb [192];
    logic [31:0] w [64];
    logic [31:0] hh [8];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    int          nblk;
    logic [31:0] bits;
    for (int i = 0; i < 128; i++) pb[i] = (i < n) ? data[1023 - 8*i -: 8] : 8'h00;
    for (int i = 128; i < 192; i++) pb[i] = 8'h00;
    pb[n] = 8'h80;
    nblk = (n + 9 + 63) / 64;
    bits = 32'(n * 8);
    pb[nblk*64 - 1] = bits[7:0];
    pb[nblk*64 - 2] = bits[15:8];
    for (int i = 0; i < 8; i++) hh[i] = TB_IV[i];
    for (int blk = 0; blk < nblk; blk++) begin
      for (int t = 0; t < 16; t++) begin
        w[t] = {pb[blk*64 + 4*t], pb[blk*64 + 4*t + 1], pb[blk*64 + 4*t + 2],
                pb[blk*64 + 4*t + 3]};
      end
      for (int t = 16; t < 64; t++) begin
        s0 = tb_rotr(w[t-15], 7) ^ tb_rotr(w[t-15], 18) ^ (w[t-15] >> 3);
        s1 = tb_rotr(w[t-2], 17) ^ tb_rotr(w[t-2], 19) ^ (w[t-2] >> 10);
        w[t] = s1 + w[t-7] + s0 + w[t-16];
      end
      a = hh[0]; b = hh[1]; c = hh[2]; d = hh[3];
      e = hh[4]; f = hh[5]; g = hh[6]; h = hh[7];
      for (int t = 0; t < 64; t++) begin
        t1 = h + (tb_rotr(e, 6) ^ tb_rotr(e, 11) ^ tb_rotr(e, 25)) + ((e & f) ^ (~e & g))
             + TB_K[t] + w[t];
        t2 = (tb_rotr(a, 2) ^ tb_rotr(a, 13) ^ tb_rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        h = g; g = f; f = e; e = d + t1;
        d = c; c = b; b = a; a = t1 + t2;
      end
      hh[0] += a; hh[1] += b; hh[2] += c; hh[3] += d;
      hh[4] += e; hh[5] += f; hh[6] += g; hh[7] += h;
    end
    return {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], hh[7]};
  endfunction

  // Called #1 after an edge; the following edge samples the request.
  task automatic start_req(input logic [1023:0] data, input logic len);
    hash_data_in   = data;
    message_length = len;
    hash_start     = 1'b1;
    @(posedge clk);
    #1;
    hash_start = 1'b0;
  endtask

  // Edges from the start-sampling edge to the first observed hash_done; -1 on timeout.
  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      #1;
      if (hash_done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_cycles(2);
    tests_run++;
    if (hash_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_done: got %b want 0", hash_done);
    end
    tests_run++;
    if (hash_data_out !== 256'h0) begin
      tests_failed++;
      $display("FAIL reset_digest: got %h want 0", hash_data_out);
    end
    reset = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_model();
    logic [1023:0] abc;
    logic [255:0]  got;
    abc = {24'h616263, 1000'h0};
    got = sha_ref(abc, 3);
    tests_run++;
    if (got !== 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad) begin
      tests_failed++;
      $display("FAIL model_abc: got %h", got);
    end
  endtask

  task automatic test_short_zero();
    int           lat;
    logic [255:0] exp_d;
    exp_d = sha_ref('0, 96);
    start_req('0, 1'b0);
    wait_done(300, lat);
    tests_run++;
    if (lat !== 132) begin
      tests_failed++;
      $display("FAIL short_latency: got %0d want 132", lat);
    end
    tests_run++;
    if (hash_data_out !== exp_d) begin
      tests_failed++;
      $display("FAIL short_digest: got %h want %h", hash_data_out, exp_d);
    end
    idle_cycles(1);
    tests_run++;
    if (hash_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL short_pulse_width: done still %b one cycle later, want 0", hash_done);
    end
    idle_cycles(3);
    tests_run++;
    if (hash_data_out !== exp_d) begin
      tests_failed++;
      $display("FAIL short_digest_hold: got %h want %h", hash_data_out, exp_d);
    end
  endtask

  task automatic test_long_pattern();
    int            lat;
    logic [1023:0] data;
    logic [255:0]  exp_d;
    for (int i = 0; i < 128; i++) data[1023 - 8*i -: 8] = 8'(i);
    exp_d = sha_ref(data, 128);
    start_req(data, 1'b1);
    wait_done(400, lat);
    tests_run++;
    if (lat !== 198) begin
      tests_failed++;
      $display("FAIL long_latency: got %0d want 198", lat);
    end
    tests_run++;
    if (hash_data_out !== exp_d) begin
      tests_failed++;
      $display("FAIL long_digest: got %h want %h", hash_data_out, exp_d);
    end
    idle_cycles(3);
  endtask

  task automatic test_busy_start();
    logic [1023:0] da, db;
    logic [255:0]  exp_d, seen;
    int            ndone, lat;
    da = {32{32'h5a5a_a5a5}};
    db = {32{32'h1111_2222}};
    exp_d = sha_ref(da, 96);
    ndone = 0;
    lat = -1;
    seen = '0;
    start_req(da, 1'b0);
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk);
      #1;
      if (k == 49) begin
        hash_start     = 1'b1;
        hash_data_in   = db;
        message_length = 1'b1;
      end
      if (k == 50) hash_start = 1'b0;
      if (hash_done) begin
        ndone++;
        if (lat < 0) begin
          lat  = k;
          seen = hash_data_out;
        end
      end
    end
    tests_run++;
    if (ndone !== 1) begin
      tests_failed++;
      $display("FAIL busy_done_count: got %0d want 1", ndone);
    end
    tests_run++;
    if (lat !== 132) begin
      tests_failed++;
      $display("FAIL busy_latency: got %0d want 132", lat);
    end
    tests_run++;
    if (seen !== exp_d) begin
      tests_failed++;
      $display("FAIL busy_digest: got %h want %h", seen, exp_d);
    end
  endtask

  task automatic test_reset_abort();
    logic [1023:0] data;
    logic [255:0]  exp_d;
    int            ndone, lat;
    ndone = 0;
    for (int i = 0; i < 128; i++) data[1023 - 8*i -: 8] = 8'(255 - i);
    start_req(data, 1'b1);
    for (int k = 1; k < 70; k++) begin
      @(posedge clk);
      #1;
      if (hash_done) ndone++;
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    tests_run++;
    if (hash_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_done: got %b want 0", hash_done);
    end
    tests_run++;
    if (hash_data_out !== 256'h0) begin
      tests_failed++;
      $display("FAIL abort_digest: got %h want 0", hash_data_out);
    end
    for (int k = 0; k < 250; k++) begin
      @(posedge clk);
      #1;
      if (hash_done) ndone++;
    end
    tests_run++;
    if (ndone !== 0) begin
      tests_failed++;
      $display("FAIL abort_no_pulse: got %0d pulses want 0", ndone);
    end
    data  = {32{32'hcafe_f00d}};
    exp_d = sha_ref(data, 96);
    start_req(data, 1'b0);
    wait_done(300, lat);
    tests_run++;
    if (lat !== 132) begin
      tests_failed++;
      $display("FAIL abort_fresh_latency: got %0d want 132", lat);
    end
    tests_run++;
    if (hash_data_out !== exp_d) begin
      tests_failed++;
      $display("FAIL abort_fresh_digest: got %h want %h", hash_data_out, exp_d);
    end
    idle_cycles(3);
  endtask

  task automatic test_back_to_back();
    logic [1023:0] d [3];
    logic          l [3];
    logic [255:0]  exp_d [3];
    logic [255:0]  held;
    int            cyc, last, ndone, set_at, stable_err, gap, want_gap;
    d[0] = {32{32'h0123_4567}}; l[0] = 1'b0;
    d[1] = {32{32'h89ab_cdef}}; l[1] = 1'b1;
    d[2] = {32{32'hfedc_ba98}}; l[2] = 1'b0;
    for (int i = 0; i < 3; i++) exp_d[i] = sha_ref(d[i], l[i] ? 128 : 96);
    cyc = 0; last = 0; ndone = 0; set_at = -1; stable_err = 0; held = '0;
    hash_data_in   = d[0];
    message_length = l[0];
    hash_start     = 1'b1;
    @(posedge clk);
    #1;
    hash_data_in   = d[1];
    message_length = l[1];
    while (ndone < 3 && cyc < 800) begin
      @(posedge clk);
      #1;
      cyc++;
      // Request 1 is sampled two edges after the first pulse (DONE, then IDLE).
      if (cyc == set_at) begin
        hash_data_in   = d[2];
        message_length = l[2];
      end
      if (hash_done) begin
        tests_run++;
        if (hash_data_out !== exp_d[ndone]) begin
          tests_failed++;
          $display("FAIL b2b_digest%0d: got %h want %h", ndone, hash_data_out, exp_d[ndone]);
        end
        if (ndone > 0) begin
          // Low cycles between pulses: IDLE cycle plus 66 per block.
          gap      = cyc - last - 1;
          want_gap = l[ndone] ? 199 : 133;
          tests_run++;
          if (gap !== want_gap) begin
            tests_failed++;
            $display("FAIL b2b_gap%0d: got %0d want %0d", ndone, gap, want_gap);
          end
        end
        if (ndone == 0) set_at = cyc + 2;
        if (ndone == 2) hash_start = 1'b0;
        held = hash_data_out;
        last = cyc;
        ndone++;
      end else if (ndone > 0 && hash_data_out !== held) begin
        stable_err++;
      end
    end
    hash_start = 1'b0;
    tests_run++;
    if (ndone !== 3) begin
      tests_failed++;
      $display("FAIL b2b_done_count: got %0d want 3", ndone);
    end
    tests_run++;
    if (stable_err !== 0) begin
      tests_failed++;
      $display("FAIL b2b_hold: digest changed %0d times between pulses, want 0", stable_err);
    end
    idle_cycles(4);
  endtask

  task automatic test_volatility();
    logic [1023:0] data;
    logic [255:0]  exp_d;
    int            lat;
    for (int i = 0; i < 32; i++) data[32*i +: 32] = 32'h1357_9bdf ^ 32'(i * 32'h0101_0101);
    exp_d = sha_ref(data, 128);
    start_req(data, 1'b1);
    lat = -1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk);
      #1;
      if (hash_done) begin
        lat = k;
        break;
      end
      for (int i = 0; i < 32; i++) hash_data_in[32*i +: 32] = $urandom();
      message_length = 1'($urandom_range(0, 1));
    end
    tests_run++;
    if (lat !== 198) begin
      tests_failed++;
      $display("FAIL volatile_latency: got %0d want 198", lat);
    end
    tests_run++;
    if (hash_data_out !== exp_d) begin
      tests_failed++;
      $display("FAIL volatile_digest: got %h want %h", hash_data_out, exp_d);
    end
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    reset          = 1'b0;
    hash_start     = 1'b0;
    hash_data_in   = '0;
    message_length = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_model();
    test_short_zero();
    test_long_pattern();
    test_busy_start();
    test_reset_abort();
    test_back_to_back();
    test_volatility();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sha256_core.md
SHA256_CORE -- requirements
Module: sha256_core

Interface
REQ-001 SHALL have parameter SHORT_MSG_BITS, default 768, meaning the message length in bits when message_length=0 (96-byte PRF input).
REQ-002 SHALL have parameter LONG_MSG_BITS, default 1024, meaning the message length in bits when message_length=1 (128-byte thash_h input).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset; one clock, reset synchronous and active-low.
REQ-005 SHALL have port hash_start, input, 1, request strobe, sampled only in IDLE.
REQ-006 SHALL have port hash_data_in, input, 1024, unpadded message, first byte in [1023:1016]; a short message occupies [1023:256] and [255:0] is ignored.
REQ-007 SHALL have port message_length, input, 1, 0 = SHORT_MSG_BITS, 1 = LONG_MSG_BITS.
REQ-008 SHALL have port hash_done, output, 1, one-cycle completion pulse.
REQ-009 SHALL have port hash_data_out, output, 256, digest; H0 in [255:224], big-endian words.

Function
REQ-010 SHALL latch hash_data_in and message_length on the edge that samples hash_start in IDLE; the initiator may change them afterwards.
REQ-011 SHALL apply FIPS 180-4 padding internally: short = 2 blocks (768 msg bits, 0x80, zeros, 64-bit length 768); long = 3 blocks (2 message blocks, then padding block 0x80 || zeros || length 1024).
REQ-012 SHALL use the FSM IDLE -> LOAD -> ROUND -> UPDATE -> (LOAD if blocks remain, else DONE) -> IDLE.
REQ-013 LOAD SHALL take 1 cycle: select the current 512-bit block, load the W window, copy H0..H7 into a..h; the first block SHALL initialise H with the standard IV.
REQ-014 ROUND SHALL take exactly 64 cycles, one compression round per cycle; a 6-bit round counter SHALL wrap from 63 to 0 on the ROUND->UPDATE transition.
REQ-015 UPDATE SHALL take 1 cycle: Hi <= Hi + reg_i, all additions modulo 2^32.
REQ-016 A block SHALL cost 66 cycles; hash_done SHALL go high 66*B edges after the start-sampling edge (B=2: 132; B=3: 198) for exactly one cycle (DONE state).
REQ-017 hash_data_out SHALL update on the same edge hash_done rises and SHALL hold until the next completion.
REQ-018 hash_start while not IDLE SHALL be ignored with no queuing; hash_start in the DONE cycle SHALL also be ignored.
REQ-019 hash_start held high continuously SHALL start a new request on each return to IDLE.
REQ-020 A block counter (2 bits) SHALL track the current block; a value of 3 SHALL be unreachable.

Reset
REQ-021 With reset=0 at a clock edge: state=IDLE, hash_done=0, hash_data_out=0, counters=0, latched message=0.
REQ-022 Reset mid-operation SHALL abort the hash with no hash_done pulse; the next request after release SHALL behave as from power-up.
REQ-023 No output SHALL depend on reset combinationally.

Structure
REQ-024 A shared package/include (sha256_pkg) SHALL hold the 64 K constants, the 8 IV words, state encodings, BLOCK_CYCLES=66 and the Ch/Maj/Σ/σ function definitions.
REQ-025 The message schedule SHALL be one sub-module, sha256_msg_schedule: a 16-word sliding window with load and shift strobes, outputting W_t each round.
REQ-026 The target size is 150-300 lines of RTL excluding the package.

Verification
REQ-027 Short all-zero: message_length=0, data=0, one start pulse -> hash_done exactly 132 cycles later, digest equal to golden SHA-256 of 96 zero bytes.
REQ-028 Long pattern: message_length=1, data bytes 0x00..0x7F ascending -> hash_done at 198 cycles, digest equal to golden SHA-256 of those 128 bytes.
REQ-029 Busy start: second hash_start at cycle 50 with different data -> it is ignored, one hash_done only, digest of the first request.
REQ-030 Reset abort: reset=0 at cycle 70 of a long hash -> no hash_done, outputs 0; a fresh short request then yields the correct digest at 132 cycles.
REQ-031 Back-to-back: hash_start held high for 3 requests with alternating lengths -> done pulses spaced 133/199 cycles apart (including the IDLE cycle), each digest correct, hash_data_out stable between pulses.
REQ-032 Input volatility: randomise hash_data_in every cycle after the start edge -> digest still matches the latched data.
